bcd_counter_n: RTL and testbench

- Parametrised N-digit BCD up/down counter; successor to the fixed 4-digit up-only display counter.
- Adds digit-count parameter, count enable, direction, synchronous clear, parallel load, and wrap/saturate mode.
- Provides terminal-count status and a wrap pulse for cascading.
- Sits between the tick/clock divider and the seven-segment digit multiplexer; the packed BCD output feeds the segment decoder directly.

---
 rtl/bcd_counter_n.sv | 89 ++++++++
 tb/tb_bcd_counter_n.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_n.sv
// N-digit packed-BCD up/down counter with clear, parallel load, and wrap/saturate boundary mode.
// Terminal-count decodes are combinational; the wrap pulse is registered alongside the count.
module bcd_counter_n #(
    parameter int DIGITS      = 4,
    parameter bit SAT_DEFAULT = 1'b0
) (
    input  logic                  clk_10Hz,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    input  logic                  up,
    input  logic                  sat,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap_pulse,
    output logic                  at_max,
    output logic                  at_min
);

    localparam int W = 4 * DIGITS;

    // Reserved parameter: mode comes from the sat input at runtime.
    logic sat_default_unused;
    assign sat_default_unused = SAT_DEFAULT;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] nib);
        return (nib > 4'd9) ? 4'd9 : nib;
    endfunction

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         wrap_q;
    logic         wrap_d;

    wire  [W-1:0]    step_val;
    wire  [W-1:0]    load_clamped;
    wire  [DIGITS:0] lo9;
    wire  [DIGITS:0] lo0;

    assign lo9[0] = 1'b1;
    assign lo0[0] = 1'b1;

    // lo9[i]/lo0[i]: every digit below i is 9 / 0, i.e. carry or borrow into digit i.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        wire [3:0] dig  = count_q[4*i +: 4];
        wire [3:0] inc  = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
        wire [3:0] dec  = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
        wire       step = up ? lo9[i] : lo0[i];

        assign lo9[i+1]              = lo9[i] & (dig == 4'd9);
        assign lo0[i+1]              = lo0[i] & (dig == 4'd0);
        assign step_val[4*i +: 4]     = step ? (up ? inc : dec) : dig;
        assign load_clamped[4*i +: 4] = clamp_bcd(load_val[4*i +: 4]);
    end

    wire boundary = up ? lo9[DIGITS] : lo0[DIGITS];

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (en) begin
            if (!(boundary && sat)) begin
                count_d = step_val;
                wrap_d  = boundary;
            end
        end
    end

    always_ff @(posedge clk_10Hz or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count      = count_q;
    assign wrap_pulse = wrap_q;
    assign at_max     = lo9[DIGITS];
    assign at_min     = lo0[DIGITS];

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: decimal-integer reference model checked every cycle,
// plus literal expectations from directed vectors on a 4-digit and a 1-digit instance.
module tb_bcd_counter_n;

    logic        clk_10Hz = 1'b0;
    logic        reset_n  = 1'b0;
    logic        clr = 1'b0, load = 1'b0, en = 1'b0, up = 1'b1, sat = 1'b0;
    logic [15:0] load_val = 16'h0;
    logic [15:0] count4;
    logic        wrap4, max4, min4;

    logic        r1_n = 1'b0;
    logic        en1  = 1'b0;
    logic [3:0]  count1;
    logic        wrap1, max1, min1;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    int m4 = 0;
    bit mw4 = 1'b0;
    int m1 = 0;
    bit mw1 = 1'b0;
    int pulses1 = 0;

    always #5 clk_10Hz = ~clk_10Hz;

    bcd_counter_n #(.DIGITS(4), .SAT_DEFAULT(1'b0)) dut4 (
        .clk_10Hz(clk_10Hz), .reset_n(reset_n), .clr(clr), .load(load),
        .load_val(load_val), .en(en), .up(up), .sat(sat),
        .count(count4), .wrap_pulse(wrap4), .at_max(max4), .at_min(min4)
    );

    bcd_counter_n #(.DIGITS(1), .SAT_DEFAULT(1'b0)) dut1 (
        .clk_10Hz(clk_10Hz), .reset_n(r1_n), .clr(1'b0), .load(1'b0),
        .load_val(4'h0), .en(en1), .up(1'b1), .sat(1'b0),
        .count(count1), .wrap_pulse(wrap1), .at_max(max1), .at_min(min1)
    );

    function automatic int pow10(input int n);
        int p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int n);
        logic [31:0] r = '0;
        int x = v;
        for (int k = 0; k < n; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Next value of an n-digit decimal counter held as a plain integer.
    function automatic void mstep(input int n, inout int v, output bit w,
                                  input bit c, input bit ld, input bit e,
                                  input bit u, input bit s, input logic [31:0] lv);
        int top = pow10(n) - 1;
        int acc = 0;
        logic [3:0] nib;
        w = 1'b0;
        if (c) begin
            v = 0;
        end else if (ld) begin
            for (int k = 0; k < n; k++) begin
                nib = lv[4*k +: 4];
                acc = acc + ((nib > 4'd9) ? 9 : int'(nib)) * pow10(k);
            end
            v = acc;
        end else if (e) begin
            if (u) begin
                if (v == top) begin
                    if (!s) begin v = 0; w = 1'b1; end
                end else v = v + 1;
            end else begin
                if (v == 0) begin
                    if (!s) begin v = top; w = 1'b1; end
                end else v = v - 1;
            end
        end
    endfunction

    always @(posedge clk_10Hz or negedge reset_n) begin
        if (!reset_n) begin m4 = 0; mw4 = 1'b0; end
        else mstep(4, m4, mw4, clr, load, en, up, sat, {16'h0, load_val});
    end

    always @(posedge clk_10Hz or negedge r1_n) begin
        if (!r1_n) begin m1 = 0; mw1 = 1'b0; end
        else mstep(1, m1, mw1, 1'b0, 1'b0, en1, 1'b1, 1'b0, 32'h0);
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_10Hz) begin
        if (chk_en) begin
            cmp("model count4", {16'h0, count4}, to_bcd(m4, 4));
            cmp("model wrap4", {31'h0, wrap4}, {31'h0, mw4});
            cmp("model at_max4", {31'h0, max4}, {31'h0, (m4 == 9999)});
            cmp("model at_min4", {31'h0, min4}, {31'h0, (m4 == 0)});
            cmp("model count1", {28'h0, count1}, to_bcd(m1, 1));
            cmp("model wrap1", {31'h0, wrap1}, {31'h0, mw1});
            cmp("model at_max1", {31'h0, max1}, {31'h0, (m1 == 9)});
            cmp("model at_min1", {31'h0, min1}, {31'h0, (m1 == 0)});
        end
    end

    task automatic tick();
        @(posedge clk_10Hz);
        @(negedge clk_10Hz);
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    initial begin
        @(negedge clk_10Hz);
        @(negedge clk_10Hz);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        cmp("reset count", {16'h0, count4}, 32'h0);
        cmp("reset at_min", {31'h0, min4}, 32'h1);
        cmp("reset at_max", {31'h0, max4}, 32'h0);
        cmp("reset wrap", {31'h0, wrap4}, 32'h0);

        // Async reset in the middle of counting.
        do_load(16'h1234);
        cmp("load 1234", {16'h0, count4}, 32'h1234);
        en = 1'b1; up = 1'b1;
        repeat (3) tick();
        cmp("mid count", {16'h0, count4}, 32'h1237);
        #2 reset_n = 1'b0;
        #1;
        cmp("async reset count", {16'h0, count4}, 32'h0);
        cmp("async reset at_min", {31'h0, min4}, 32'h1);
        @(negedge clk_10Hz);
        reset_n = 1'b1;
        repeat (12) tick();
        cmp("count 12", {16'h0, count4}, 32'h0012);

        // Carry across digits and load clamping.
        en = 1'b0;
        do_load(16'h0998);
        cmp("load 0998", {16'h0, count4}, 32'h0998);
        en = 1'b1; up = 1'b1; sat = 1'b0;
        tick();
        cmp("inc 0999", {16'h0, count4}, 32'h0999);
        tick();
        cmp("carry 1000", {16'h0, count4}, 32'h1000);
        en = 1'b0;
        do_load(16'h0ABF);
        cmp("clamp 0ABF", {16'h0, count4}, 32'h0999);

        // Upper boundary, wrap then saturate.
        do_load(16'h9999);
        cmp("at_max 9999", {31'h0, max4}, 32'h1);
        en = 1'b1;
        tick();
        cmp("wrap up count", {16'h0, count4}, 32'h0);
        cmp("wrap up pulse", {31'h0, wrap4}, 32'h1);
        en = 1'b0;
        tick();
        cmp("wrap pulse drops", {31'h0, wrap4}, 32'h0);
        do_load(16'h9999);
        en = 1'b1; sat = 1'b1;
        tick();
        cmp("sat up count", {16'h0, count4}, 32'h9999);
        cmp("sat up pulse", {31'h0, wrap4}, 32'h0);
        cmp("sat up at_max", {31'h0, max4}, 32'h1);

        // Borrow and lower boundary.
        en = 1'b0; sat = 1'b0;
        do_load(16'h1000);
        en = 1'b1; up = 1'b0;
        tick();
        cmp("borrow 0999", {16'h0, count4}, 32'h0999);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cmp("clear", {16'h0, count4}, 32'h0);
        tick();
        cmp("wrap down count", {16'h0, count4}, 32'h9999);
        cmp("wrap down pulse", {31'h0, wrap4}, 32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0; sat = 1'b1;
        tick();
        cmp("sat down count", {16'h0, count4}, 32'h0);
        cmp("sat down pulse", {31'h0, wrap4}, 32'h0);
        cmp("sat down at_min", {31'h0, min4}, 32'h1);

        // Priority clr > load > en.
        sat = 1'b0; up = 1'b1;
        clr = 1'b1; load = 1'b1; load_val = 16'h1234;
        tick();
        cmp("prio clr", {16'h0, count4}, 32'h0);
        clr = 1'b0; load_val = 16'h0042;
        tick();
        load = 1'b0;
        cmp("prio load", {16'h0, count4}, 32'h0042);

        // Direction toggling every cycle, model tracks it.
        for (int k = 0; k < 8; k++) begin
            up = k[0];
            tick();
        end
        en = 1'b0;
        tick();

        // One-digit instance: 25 enabled edges from reset.
        r1_n = 1'b1;
        en1  = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (wrap1) pulses1++;
        end
        en1 = 1'b0;
        cmp("digit1 count", {28'h0, count1}, 32'h5);
        cmp("digit1 pulses", pulses1, 32'd2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
